enode_net_port: RTL and testbench

- Per-E-node adapter between an E-node's ALU/reservation stations and its local port on the operand switching network.
- **TX side:** buffers ALU results that carry up to two targets, then serialises them into single-flit network injections on the req/ack handshake.
- **RX side:** accepts operands the network delivers to this node and writes them into the reservation stations.
- One instance per E-node in the E-tile array, facing that node's local router port.

---
 rtl/enode_net_port.sv | 164 ++++++++++++++++
 tb/tb_enode_net_port.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enode_net_port.sv
// rtl/enode_net_port.sv - E-node operand network port: TX result FIFO/serialiser and RX RS writer
// Optional RX skid register: define OPNET_RX_SKID_EN.
module enode_net_port #(
    parameter int RES_FIFO_DEPTH = 4,
    parameter int NODE_ID        = 0,
    parameter int OPERAND_W      = 64,
    parameter int INSTR_W        = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    input  logic [OPERAND_W-1:0]      res_operand_i,
    input  logic [1:0]                res_tgt_valid_i,
    input  logic [1:0][INSTR_W-1:0]   res_tgt_instr_i,
    input  logic [1:0][1:0]           res_tgt_slot_i,
    output logic [OPERAND_W-1:0]      net_operand_o,
    output logic [INSTR_W-1:0]        net_dest_instr_o,
    output logic [1:0]                net_dest_slot_o,
    output logic                      net_req_o,
    input  logic                      net_ack_i,
    input  logic [OPERAND_W-1:0]      net_operand_i,
    input  logic [INSTR_W-1:0]        net_dest_instr_i,
    input  logic [1:0]                net_dest_slot_i,
    input  logic                      net_req_i,
    output logic                      net_ack_o,
    output logic                      rs_wr_en_o,
    output logic [INSTR_W-1:0]        rs_wr_instr_o,
    output logic [1:0]                rs_wr_slot_o,
    output logic [OPERAND_W-1:0]      rs_wr_operand_o,
    input  logic                      rs_wr_ready_i,
    output logic                      err_slot_o
);
    localparam int PTR_W = (RES_FIFO_DEPTH > 1) ? $clog2(RES_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OPERAND_W-1:0]    operand;
        logic [1:0]              tv;
        logic [1:0][INSTR_W-1:0] instr;
        logic [1:0][1:0]         slot;
    } res_entry_t;

    typedef enum logic {T0, T1} tgt_sel_e;

    res_entry_t fifo_q [RES_FIFO_DEPTH];
    res_entry_t fifo_d [RES_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    tgt_sel_e         tgt_sel_q, tgt_sel_d;
    logic             err_slot_q, err_slot_d;
    logic             run_q;

    res_entry_t head;
    logic       sel_idx, fifo_empty, cur_tv, tx_inject, tx_bad, tx_adv, push, pop;
    logic       rx_bad, rx_err;

`ifdef OPNET_RX_SKID_EN
    logic                 skid_full_q, skid_full_d;
    logic [OPERAND_W-1:0] skid_operand_q, skid_operand_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [1:0]           skid_slot_q, skid_slot_d;
    logic                 rx_fill, rx_drain;
`endif

    always_comb begin
        head       = fifo_q[rd_ptr_q];
        sel_idx    = (tgt_sel_q == T1);
        fifo_empty = (count_q == '0);
        cur_tv     = head.tv[sel_idx];
        tx_inject  = !fifo_empty && cur_tv && (head.slot[sel_idx] != 2'd3);
        tx_bad     = !fifo_empty && cur_tv && (head.slot[sel_idx] == 2'd3);
        net_req_o  = tx_inject && !flush_i;
        // Skipped targets advance without waiting on the network.
        tx_adv     = !fifo_empty && !flush_i && (!tx_inject || net_ack_i);
        pop        = tx_adv && sel_idx;

        net_operand_o    = net_req_o ? head.operand        : '0;
        net_dest_instr_o = net_req_o ? head.instr[sel_idx] : '0;
        net_dest_slot_o  = net_req_o ? head.slot[sel_idx]  : '0;

        res_ready_o = (count_q != CNT_W'(RES_FIFO_DEPTH)) && !flush_i;
        push        = res_valid_i && res_ready_o;

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{operand: res_operand_i, tv: res_tgt_valid_i,
                                 instr: res_tgt_instr_i, slot: res_tgt_slot_i};
        end
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        tgt_sel_d = tx_adv ? (sel_idx ? T0 : T1) : tgt_sel_q;
        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            tgt_sel_d = T0;
        end

        rx_bad = (net_dest_slot_i == 2'd3);
`ifdef OPNET_RX_SKID_EN
        // Accept into a full skid only when it drains in the same cycle.
        net_ack_o       = run_q && net_req_i && (flush_i || !skid_full_q || rs_wr_ready_i);
        rx_fill         = net_ack_o && !rx_bad && !flush_i;
        rs_wr_en_o      = skid_full_q && !flush_i;
        rx_drain        = rs_wr_en_o && rs_wr_ready_i;
        skid_full_d     = !flush_i && (rx_fill || (skid_full_q && !rx_drain));
        skid_operand_d  = rx_fill ? net_operand_i    : skid_operand_q;
        skid_instr_d    = rx_fill ? net_dest_instr_i : skid_instr_q;
        skid_slot_d     = rx_fill ? net_dest_slot_i  : skid_slot_q;
        rs_wr_instr_o   = skid_instr_q;
        rs_wr_slot_o    = skid_slot_q;
        rs_wr_operand_o = skid_operand_q;
`else
        net_ack_o       = run_q && net_req_i && (flush_i || rx_bad || rs_wr_ready_i);
        rs_wr_en_o      = run_q && net_req_i && rs_wr_ready_i && !rx_bad && !flush_i;
        rs_wr_instr_o   = rs_wr_en_o ? net_dest_instr_i : '0;
        rs_wr_slot_o    = rs_wr_en_o ? net_dest_slot_i  : '0;
        rs_wr_operand_o = rs_wr_en_o ? net_operand_i    : '0;
`endif
        rx_err     = net_ack_o && rx_bad;
        err_slot_d = err_slot_q || (tx_bad && tx_adv) || rx_err;
        err_slot_o = err_slot_q;
    end

    // run_q keeps net_ack_o low while in reset, dropping it asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RES_FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tgt_sel_q  <= T0;
            err_slot_q <= 1'b0;
            run_q      <= 1'b0;
`ifdef OPNET_RX_SKID_EN
            skid_full_q    <= 1'b0;
            skid_operand_q <= '0;
            skid_instr_q   <= '0;
            skid_slot_q    <= '0;
`endif
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tgt_sel_q  <= tgt_sel_d;
            err_slot_q <= err_slot_d;
            run_q      <= 1'b1;
`ifdef OPNET_RX_SKID_EN
            skid_full_q    <= skid_full_d;
            skid_operand_q <= skid_operand_d;
            skid_instr_q   <= skid_instr_d;
            skid_slot_q    <= skid_slot_d;
`endif
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(RES_FIFO_DEPTH))
        else $error("enode_net_port %0d: result FIFO count overflow", NODE_ID);

endmodule

// File: tb/tb_enode_net_port.sv
// tb/tb_enode_net_port.sv - directed self-checking bench for enode_net_port
module tb_enode_net_port;
    logic             clk, rst_n, flush_i;
    logic             res_valid_i, res_ready_o;
    logic [63:0]      res_operand_i;
    logic [1:0]       res_tgt_valid_i;
    logic [1:0][6:0]  res_tgt_instr_i;
    logic [1:0][1:0]  res_tgt_slot_i;
    logic [63:0]      net_operand_o;
    logic [6:0]       net_dest_instr_o;
    logic [1:0]       net_dest_slot_o;
    logic             net_req_o, net_ack_i;
    logic [63:0]      net_operand_i;
    logic [6:0]       net_dest_instr_i;
    logic [1:0]       net_dest_slot_i;
    logic             net_req_i, net_ack_o;
    logic             rs_wr_en_o;
    logic [6:0]       rs_wr_instr_o;
    logic [1:0]       rs_wr_slot_o;
    logic [63:0]      rs_wr_operand_o;
    logic             rs_wr_ready_i, err_slot_o;

    int checks = 0;
    int failures = 0;

    enode_net_port #(.RES_FIFO_DEPTH(4), .NODE_ID(0), .OPERAND_W(64), .INSTR_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_operand_i(res_operand_i),
        .res_tgt_valid_i(res_tgt_valid_i), .res_tgt_instr_i(res_tgt_instr_i),
        .res_tgt_slot_i(res_tgt_slot_i),
        .net_operand_o(net_operand_o), .net_dest_instr_o(net_dest_instr_o),
        .net_dest_slot_o(net_dest_slot_o), .net_req_o(net_req_o), .net_ack_i(net_ack_i),
        .net_operand_i(net_operand_i), .net_dest_instr_i(net_dest_instr_i),
        .net_dest_slot_i(net_dest_slot_i), .net_req_i(net_req_i), .net_ack_o(net_ack_o),
        .rs_wr_en_o(rs_wr_en_o), .rs_wr_instr_o(rs_wr_instr_o), .rs_wr_slot_o(rs_wr_slot_o),
        .rs_wr_operand_o(rs_wr_operand_o), .rs_wr_ready_i(rs_wr_ready_i),
        .err_slot_o(err_slot_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic [63:0] op, input logic [1:0] tv,
                           input logic [6:0] i0, input logic [1:0] s0,
                           input logic [6:0] i1, input logic [1:0] s1);
        res_valid_i        = 1'b1;
        res_operand_i      = op;
        res_tgt_valid_i    = tv;
        res_tgt_instr_i[0] = i0;
        res_tgt_slot_i[0]  = s0;
        res_tgt_instr_i[1] = i1;
        res_tgt_slot_i[1]  = s1;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; res_valid_i = 1'b0; res_operand_i = '0;
        res_tgt_valid_i = '0; res_tgt_instr_i = '0; res_tgt_slot_i = '0;
        net_ack_i = 1'b0; net_operand_i = 64'h3; net_dest_instr_i = 7'd1; net_dest_slot_i = 2'd1;
        net_req_i = 1'b1; rs_wr_ready_i = 1'b1;

        // Reset state with an RX flit offered
        step(); step();
        chk("rst_net_req", net_req_o, 0);
        chk("rst_net_ack", net_ack_o, 0);
        chk("rst_rs_wr_en", rs_wr_en_o, 0);
        chk("rst_err", err_slot_o, 0);
        chk("rst_res_ready", res_ready_o, 1);
        chk("rst_rs_instr", rs_wr_instr_o, 0);
        net_req_i = 1'b0; rs_wr_ready_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step(); step();

        // Dual-target result under continuous ack
        set_res(64'h5, 2'b11, 7'd12, 2'd0, 7'd40, 2'd2);
        net_ack_i = 1'b1;
        step();
        res_valid_i = 1'b0;
        @(negedge clk);
        chk("dual_req0", net_req_o, 1);
        chk("dual_instr0", net_dest_instr_o, 12);
        chk("dual_slot0", net_dest_slot_o, 0);
        chk("dual_op0", net_operand_o, 5);
        step(); @(negedge clk);
        chk("dual_req1", net_req_o, 1);
        chk("dual_instr1", net_dest_instr_o, 40);
        chk("dual_slot1", net_dest_slot_o, 2);
        step(); @(negedge clk);
        chk("dual_empty", net_req_o, 0);

        // Backpressure: fill four, fifth refused, then eight flits in order
        step();
        net_ack_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_res(64'h10 + 64'(k), 2'b11, 7'(k), 2'd0, 7'(k + 20), 2'd1);
            step();
        end
        set_res(64'h99, 2'b11, 7'd99, 2'd0, 7'd98, 2'd1);
        @(negedge clk);
        chk("bp_full_ready", res_ready_o, 0);
        chk("bp_hold_req", net_req_o, 1);
        chk("bp_hold_instr", net_dest_instr_o, 0);
        step();
        res_valid_i = 1'b0;
        net_ack_i = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("bp_req", net_req_o, 1);
            chk("bp_instr", net_dest_instr_o, (j % 2 == 1) ? 64'(j / 2 + 20) : 64'(j / 2));
            chk("bp_slot", net_dest_slot_o, 64'(j % 2));
            chk("bp_op", net_operand_o, 64'h10 + 64'(j / 2));
            step();
        end
        @(negedge clk);
        chk("bp_drained", net_req_o, 0);
        chk("bp_ready", res_ready_o, 1);

        // Only target 1 valid
        step();
        set_res(64'h21, 2'b10, 7'd5, 2'd0, 7'd33, 2'd1);
        step();
        res_valid_i = 1'b0;
        @(negedge clk);
        chk("skip0_req", net_req_o, 0);
        step(); @(negedge clk);
        chk("skip1_req", net_req_o, 1);
        chk("skip1_instr", net_dest_instr_o, 33);
        step(); @(negedge clk);
        chk("skip_done", net_req_o, 0);

        // No-target entry popped after two cycles, next entry then injects
        step();
        set_res(64'h31, 2'b00, 7'd1, 2'd0, 7'd2, 2'd0);
        step();
        set_res(64'h32, 2'b01, 7'd9, 2'd0, 7'd0, 2'd0);
        @(negedge clk);
        chk("none_t0_req", net_req_o, 0);
        step();
        res_valid_i = 1'b0;
        @(negedge clk);
        chk("none_t1_req", net_req_o, 0);
        step(); @(negedge clk);
        chk("none_next_req", net_req_o, 1);
        chk("none_next_instr", net_dest_instr_o, 9);
        chk("none_next_op", net_operand_o, 64'h32);
        step(); @(negedge clk);
        chk("none_next_skip1", net_req_o, 0);
        step();

        // Illegal TX slot
        @(negedge clk);
        chk("bad_err_before", err_slot_o, 0);
        step();
        set_res(64'h41, 2'b01, 7'd3, 2'd3, 7'd0, 2'd0);
        step();
        res_valid_i = 1'b0;
        @(negedge clk);
        chk("bad_req", net_req_o, 0);
        step(); @(negedge clk);
        chk("bad_err_set", err_slot_o, 1);
        chk("bad_req_t1", net_req_o, 0);
        step(); @(negedge clk);
        chk("bad_ready", res_ready_o, 1);
        chk("bad_err_sticky", err_slot_o, 1);
        step();

        // RX with RS stall
        net_req_i = 1'b1; net_dest_instr_i = 7'd7; net_dest_slot_i = 2'd1;
        net_operand_i = 64'h77; rs_wr_ready_i = 1'b0;
`ifdef OPNET_RX_SKID_EN
        @(negedge clk);
        chk("rx_skid_ack0", net_ack_o, 1);
        chk("rx_skid_wr0", rs_wr_en_o, 0);
        step();
        net_dest_instr_i = 7'd8; net_dest_slot_i = 2'd0; net_operand_i = 64'h88;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rx_skid_hold_ack", net_ack_o, 0);
            chk("rx_skid_hold_wr", rs_wr_en_o, 1);
            chk("rx_skid_hold_instr", rs_wr_instr_o, 7);
            step();
        end
        rs_wr_ready_i = 1'b1;
        @(negedge clk);
        chk("rx_skid_ack1", net_ack_o, 1);
        chk("rx_skid_wr_instr", rs_wr_instr_o, 7);
        chk("rx_skid_wr_slot", rs_wr_slot_o, 1);
        chk("rx_skid_wr_op", rs_wr_operand_o, 64'h77);
        step();
        net_req_i = 1'b0;
        @(negedge clk);
        chk("rx_skid_wr2", rs_wr_en_o, 1);
        chk("rx_skid_wr2_instr", rs_wr_instr_o, 8);
        step(); @(negedge clk);
        chk("rx_skid_empty", rs_wr_en_o, 0);
        rs_wr_ready_i = 1'b0;
        step();
`else
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rx_stall_ack", net_ack_o, 0);
            chk("rx_stall_wr", rs_wr_en_o, 0);
            step();
        end
        rs_wr_ready_i = 1'b1;
        @(negedge clk);
        chk("rx_ack", net_ack_o, 1);
        chk("rx_wr", rs_wr_en_o, 1);
        chk("rx_wr_instr", rs_wr_instr_o, 7);
        chk("rx_wr_slot", rs_wr_slot_o, 1);
        chk("rx_wr_op", rs_wr_operand_o, 64'h77);
        step();
        net_req_i = 1'b0;
        @(negedge clk);
        chk("rx_wr_once", rs_wr_en_o, 0);
        rs_wr_ready_i = 1'b0;
        step();
`endif
        // Illegal RX slot is acked and dropped even with the RS stalled
        net_req_i = 1'b1; net_dest_instr_i = 7'd2; net_dest_slot_i = 2'd3;
        @(negedge clk);
        chk("rx_bad_ack", net_ack_o, 1);
        chk("rx_bad_wr", rs_wr_en_o, 0);
        step();
        net_req_i = 1'b0;
        @(negedge clk);
        chk("rx_bad_dropped", rs_wr_en_o, 0);
        step();

        // Flush after target 0 acked
        net_ack_i = 1'b1;
        set_res(64'h51, 2'b11, 7'd50, 2'd0, 7'd51, 2'd1);
        step();
        res_valid_i = 1'b0;
        @(negedge clk);
        chk("fl_t0_instr", net_dest_instr_o, 50);
        step();
        flush_i = 1'b1; net_req_i = 1'b1; net_dest_slot_i = 2'd1; net_dest_instr_i = 7'd4;
        @(negedge clk);
        chk("fl_req", net_req_o, 0);
        chk("fl_ready", res_ready_o, 0);
        chk("fl_ack", net_ack_o, 1);
        chk("fl_wr", rs_wr_en_o, 0);
        step();
        flush_i = 1'b0; net_req_i = 1'b0;
        @(negedge clk);
        chk("fl_after_req", net_req_o, 0);
        chk("fl_after_ready", res_ready_o, 1);
        chk("fl_after_wr", rs_wr_en_o, 0);
        step(); @(negedge clk);
        chk("fl_t1_never", net_req_o, 0);
        step();

        // Asynchronous reset mid-handshake
        net_ack_i = 1'b0;
        set_res(64'h61, 2'b01, 7'd60, 2'd0, 7'd0, 2'd0);
        step();
        res_valid_i = 1'b0;
        net_req_i = 1'b1; rs_wr_ready_i = 1'b1; net_dest_slot_i = 2'd1;
        @(negedge clk);
        chk("ar_req_pre", net_req_o, 1);
        chk("ar_ack_pre", net_ack_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", net_req_o, 0);
        chk("ar_ack", net_ack_o, 0);
        chk("ar_wr", rs_wr_en_o, 0);
        chk("ar_err", err_slot_o, 0);
        chk("ar_ready", res_ready_o, 1);
        chk("ar_instr", net_dest_instr_o, 0);
        chk("ar_op", net_operand_o, 0);
        chk("ar_rs_op", rs_wr_operand_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
